alu_serial: RTL and testbench
=============================

Name: alu_serial

Overview:
- Parametrised, multi-cycle successor to the MU0 16-bit ripple ALU.
- Processes operands in SLICE-bit digits, one digit per clock, LSB first, with a start/busy/done handshake.
- Extends the 2-bit function set (B, B+1, A+B, A-B) with logical ops and Z/N/C/V flags.
- Intended for a wider or area-constrained datapath. The control FSM holds the ALU result until done.

Parameters:
- WIDTH, 16: operand/result width. Must be a multiple of SLICE.
- SLICE, 4: bits processed per cycle. SLICE = WIDTH gives single-pass operation, still 1 cycle of latency.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: request an operation. Sampled only while busy = 0.
- op, input, 3: function select. Encoding listed under Behaviour.
- a, input, WIDTH: operand A. Sampled on the accepted start edge.
- b, input, WIDTH: operand B. Sampled on the accepted start edge.
- busy, output, 1: operation in progress.
- done, output, 1: one-cycle pulse; result and flags are valid from this cycle.
- alu, output, WIDTH: result register.
- z, output, 1: result == 0.
- n, output, 1: result MSB.
- c, output, 1: carry out of MSB.
- v, output, 1: signed overflow.

Behaviour:
- Reset (asynchronous): busy, done, alu, z, n, c, v, the internal counter and the operand registers all clear to 0. FSM goes to IDLE.
- Reset mid-operation aborts the operation; no done is produced.
- Digit count: N = WIDTH/SLICE. The counter is ceil(log2(N)) bits wide, minimum 1.
- op encoding:
  - 000: B (0+B+0)
  - 001: B+1 (0+B+1)
  - 010: A+B (A+B+0)
  - 011: A-B (A+~B+1)
  - 100: A&B
  - 101: A|B
  - 110: A^B
  - 111: ~B
  - op[2] = 0 matches the legacy 2-bit encoding.
- FSM states: IDLE and RUN.
- IDLE:
  - start = 1 at an edge latches a, b and op, clears the counter, and sets the carry register to 1 if op is 001 or 011 (0 otherwise).
  - Enters RUN; busy = 1 from the next cycle.
- RUN, each edge:
  - Computes slice [cnt*SLICE +: SLICE] from the latched operands and the carry register.
  - Stores it into the working register and updates the carry register.
  - Increments cnt.
- Last slice (cnt = N-1), at that edge:
  - alu <= full working result, including the final slice.
  - Flags update.
  - done <= 1, busy <= 0, FSM returns to IDLE.
- Latency: start accepted at edge k gives done high and alu valid after edge k+N. Throughput is one operation per N+1 cycles.
- done is high for exactly one cycle.
- alu and the flags hold until the next completion. They do not change during RUN.
- start while busy = 1 is ignored; no queuing.
- start in the done cycle is accepted (busy = 0). done then falls and busy rises at the next edge.
- Input changes on a or b after acceptance have no effect.
- Arithmetic ops (op[2] = 0):
  - c = carry out of the MSB. For A-B, c = 1 means no borrow.
  - v = carry into MSB XOR carry out of MSB.
- Logical ops: c = 0, v = 0.
- All ops: z and n are derived from the final result.
- Results wrap modulo 2^WIDTH.

Test Plan:
1. WIDTH=16, SLICE=4, op=010, a=0x1234, b=0x0FFF, start one cycle -> busy high for 4 cycles; done pulses 4 cycles after the start edge; alu=0x2233, z=0, n=0, c=0, v=0.
2. op=011, a=0x0005, b=0x0007 -> alu=0xFFFE, n=1, c=0 (borrow), v=0. Then a=0x8000, b=0x0001 -> alu=0x7FFF, c=1, v=1.
3. op=001, b=0xFFFF -> alu=0x0000, z=1, c=1, v=0. Then op=001, b=0x7FFF -> alu=0x8000, v=1, n=1.
4. op=100/101/110/111 with a=0xF0F0, b=0xFF00 -> alu=0xF000/0xFFF0/0x0FF0/0x00FF respectively; c=0, v=0.
5. start held high continuously; a and b changed every cycle during RUN -> new operations accepted every 5 cycles; each result uses only the operands sampled at its accepting edge; start during busy is ignored.
6. Assert reset two cycles into RUN -> all outputs 0 immediately, no done pulse. After release, op=000, b=0xABCD -> alu=0xABCD after 4 cycles. Repeat case 1 with SLICE=16 -> done 1 cycle after start.

Source files
------------

// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial
// Brief    : Digit-serial ALU processing SLICE bits per clock, LSB first,
//            with start/busy/done handshake and Z/N/C/V flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    localparam int c_N  = WIDTH / SLICE;
    localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic [2:0]       r_op;
    logic             r_carry;

    logic [SLICE-1:0] w_aop;
    logic [SLICE-1:0] w_bop;
    logic [SLICE:0]   w_ext;
    logic [SLICE-1:0] w_slice;
    logic             w_cout;
    logic             w_msb_cin;
    logic             w_arith;
    logic [WIDTH-1:0] w_work_next;

    // Operand registers shift right each digit so the current digit is
    // always in the low SLICE bits.
    always_comb begin
        w_arith   = ~r_op[2];
        w_aop     = r_op[1] ? r_a[SLICE-1:0] : '0;
        w_bop     = (r_op[1:0] == 2'b11) ? ~r_b[SLICE-1:0] : r_b[SLICE-1:0];
        w_ext     = {1'b0, w_aop} + {1'b0, w_bop} + {{SLICE{1'b0}}, r_carry};
        w_cout    = w_ext[SLICE];
        // Carry into the digit MSB recovered from the MSB sum bit.
        w_msb_cin = w_aop[SLICE-1] ^ w_bop[SLICE-1] ^ w_ext[SLICE-1];
        case (r_op)
            3'b100:  w_slice = r_a[SLICE-1:0] & r_b[SLICE-1:0];
            3'b101:  w_slice = r_a[SLICE-1:0] | r_b[SLICE-1:0];
            3'b110:  w_slice = r_a[SLICE-1:0] ^ r_b[SLICE-1:0];
            3'b111:  w_slice = ~r_b[SLICE-1:0];
            default: w_slice = w_ext[SLICE-1:0];
        endcase
        w_work_next = WIDTH'({w_slice, r_work} >> SLICE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_op    <= '0;
            r_carry <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu     <= '0;
            z       <= 1'b0;
            n       <= 1'b0;
            c       <= 1'b0;
            v       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_cnt   <= '0;
                        r_carry <= (op == 3'b001) || (op == 3'b011);
                        busy    <= 1'b1;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_a     <= r_a >> SLICE;
                    r_b     <= r_b >> SLICE;
                    r_work  <= w_work_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + c_CW'(1);
                    if (r_cnt == c_LAST) begin
                        alu     <= w_work_next;
                        z       <= (w_work_next == '0);
                        n       <= w_work_next[WIDTH-1];
                        c       <= w_arith & w_cout;
                        v       <= w_arith & (w_cout ^ w_msb_cin);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_serial
// Brief    : Self-checking bench for alu_serial (SLICE=4 and SLICE=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_serial;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        busy, done, z, n, c, v;
    logic [15:0] alu;
    logic        w1_busy, w1_done, w1_z, w1_n, w1_c, w1_v;
    logic [15:0] w1_alu;

    int n_checks = 0;
    int n_errors = 0;

    alu_serial #(.WIDTH(16), .SLICE(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .alu(alu), .z(z), .n(n), .c(c), .v(v)
    );

    alu_serial #(.WIDTH(16), .SLICE(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(w1_busy), .done(w1_done), .alu(w1_alu), .z(w1_z), .n(w1_n),
        .c(w1_c), .v(w1_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] alu;
        logic        z, n, c, v;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: full-width arithmetic, overflow from operand/result signs.
    function automatic logic [19:0] model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] ea, eb, r;
        logic        ci, cf, vf;
        logic [16:0] s;
        ea = 16'h0; eb = y; ci = 1'b0; cf = 1'b0; vf = 1'b0; r = 16'h0;
        case (o)
            3'b000: begin ea = 16'h0; eb = y;  ci = 1'b0; end
            3'b001: begin ea = 16'h0; eb = y;  ci = 1'b1; end
            3'b010: begin ea = x;     eb = y;  ci = 1'b0; end
            3'b011: begin ea = x;     eb = ~y; ci = 1'b1; end
            default: ;
        endcase
        if (!o[2]) begin
            s  = {1'b0, ea} + {1'b0, eb} + {16'h0, ci};
            r  = s[15:0];
            cf = s[16];
            vf = (ea[15] == eb[15]) && (r[15] != ea[15]);
        end else begin
            case (o)
                3'b100:  r = x & y;
                3'b101:  r = x | y;
                3'b110:  r = x ^ y;
                default: r = ~y;
            endcase
        end
        return {r, (r == 16'h0), r[15], cf, vf};
    endfunction

    // One operation on the SLICE=4 instance; returns {alu,z,n,c,v}.
    task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                          output logic [19:0] res);
        int          lat;
        int          w;
        logic [15:0] prev;
        @(negedge clk);
        w = 0;
        while (busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        prev = alu;
        lat = 0;
        while (!done && lat < 20) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("alu_hold", 32'(alu), 32'(prev));
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 4);
        chk("busy_done", 32'(busy), 32'd0);
        res = {alu, z, n, c, v};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [19:0] r;
        logic [19:0] m;
        logic [2:0]  o;
        logic [15:0] x, y;
        int          rem;
        int          accepts;
        int          dcount;
        logic        exp_done;

        vecs[0] = '{3'b010, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{3'b011, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{3'b011, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{3'b001, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{3'b001, 16'h0000, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{3'b100, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{3'b101, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{3'b110, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{3'b111, 16'hF0F0, 16'hFF00, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{3'b000, 16'h1111, 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {busy, done, z, n, c, v, alu}, 32'd0);
        chk("rst_outputs16", {w1_busy, w1_done, w1_z, w1_n, w1_c, w1_v, w1_alu}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r);
            chk($sformatf("vec%0d_alu", i), 32'(r[19:4]), 32'(vecs[i].alu));
            chk($sformatf("vec%0d_zncv", i), 32'(r[3:0]),
                32'({vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v}));
        end

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       x = 16'hFFFF;
                1:       x = 16'h8000;
                default: x = 16'($urandom);
            endcase
            y = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            run_op(o, x, y, r);
            m = model(o, x, y);
            chk($sformatf("rand%0d_op%0d", i, o), 32'(r), 32'(m));
        end

        // Start held high, operands churning every cycle.
        @(negedge clk);
        rem = 0;
        accepts = 0;
        m = '0;
        start = 1'b1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            op = 3'($urandom_range(0, 7));
            @(posedge clk);
            if (rem == 0) begin
                m = model(op, a, b);
                rem = 4;
                exp_done = 1'b0;
                accepts++;
            end else begin
                rem--;
                exp_done = (rem == 0);
            end
            #1;
            chk("stream_done", 32'(done), 32'(exp_done));
            chk("stream_busy", 32'(busy), 32'(rem != 0));
            if (exp_done) chk("stream_result", 32'({alu, z, n, c, v}), 32'(m));
            @(negedge clk);
        end
        start = 1'b0;
        chk("stream_accepts", accepts, 5);

        // Reset two cycles into RUN.
        run_op(3'b010, 16'h1234, 16'h0FFF, r);
        @(negedge clk);
        op = 3'b010; a = 16'h4321; b = 16'h1111; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_outputs", {busy, done, z, n, c, v, alu}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        run_op(3'b000, 16'h0000, 16'hABCD, r);
        chk("post_reset_alu", 32'(r[19:4]), 32'h0000ABCD);

        // Single-pass instance alongside the 4-digit one.
        repeat (3) @(negedge clk);
        op = 3'b010; a = 16'h1234; b = 16'h0FFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("s16_busy_before", 32'(w1_busy), 32'd1);
        chk("s4_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("s16_done", 32'(w1_done), 32'd1);
        chk("s16_result", 32'({w1_alu, w1_z, w1_n, w1_c, w1_v}), 32'({16'h2233, 4'b0000}));
        chk("s4_not_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("s4_done", 32'(done), 32'd1);
        chk("s4_result", 32'(alu), 32'h00002233);
        chk("s16_done_pulse", 32'(w1_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
